johnson_seq_checker: RTL

//  Receive-side partner of the N-bit Johnson counter. Samples a Johnson code word each valid cycle,

---
 rtl/johnson_pkg.sv | 43 ++++
 rtl/johnson_seq_checker_if.sv | 30 +++
 rtl/johnson_code_decode.sv | 21 ++
 rtl/johnson_seq_checker.sv | 117 +++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and the Johnson-code decode function used by the checker and by the
// counter's own self-check assertions.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  // Widest code the decode function accepts; callers zero-extend narrower words.
  localparam int MAX_N = 32;

  typedef struct packed {
    logic       legal;
    logic [7:0] index;
  } jdec_t;

  // Index width for an n-bit Johnson code (2n phases).
  function automatic int idx_w(input int n);
    return $clog2(2 * n);
  endfunction

  // A word is a Johnson state iff its n bits contain at most one 0/1 boundary.
  // Low-filled words (MSB=0) map to their popcount, high-filled words to 2n - popcount.
  function automatic jdec_t johnson_idx(input logic [MAX_N-1:0] code, input int n);
    jdec_t res;
    int    ones;
    int    edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) ones += int'(code[i]);
    end
    for (int i = 1; i < MAX_N; i++) begin
      if (i < n && code[i] != code[i-1]) edges++;
    end
    res.legal = (edges <= 1);
    res.index = code[n-1] ? 8'(2 * n - ones) : 8'(ones);
    return res;
  endfunction

endpackage

// File: rtl/johnson_seq_checker_if.sv
// Code-word input and checker result bundle between a Johnson phase source and the checker.
interface johnson_seq_checker_if
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int ERR_W = 8
);
  localparam int IDX_W = idx_w(N);

  logic [N-1:0]     code_in;
  logic             code_valid;
  logic [IDX_W-1:0] index_out;
  logic             index_valid;
  logic             illegal_code;
  logic             seq_error;
  logic             locked;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output code_in, code_valid,
    input  index_out, index_valid, illegal_code, seq_error, locked, wrap_pulse, err_count
  );

  modport slave (
    input  code_in, code_valid,
    output index_out, index_valid, illegal_code, seq_error, locked, wrap_pulse, err_count
  );

endinterface

// File: rtl/johnson_code_decode.sv
// Combinational Johnson word decoder: flags legality and returns the phase index.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     code,
  output logic             legal,
  output logic [IDX_W-1:0] index
);

  jdec_t dec;

  always_comb begin
    dec   = johnson_idx(MAX_N'(code), N);
    legal = dec.legal;
    index = IDX_W'(dec.index);
  end

endmodule

// File: rtl/johnson_seq_checker.sv
// Receive-side Johnson sequence checker: registers the incoming word, decodes it,
// tracks lock with a three-state FSM and reports errors through registered outputs.
module johnson_seq_checker
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  johnson_seq_checker_if.slave  bus
);

  localparam int               IDX_W    = idx_w(N);
  localparam int               GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);

  logic [N-1:0]      code_q;
  logic              valid_q;
  logic              legal;
  logic [IDX_W-1:0]  idx;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ref_q, ref_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [IDX_W-1:0]  succ;
  logic              is_succ;
  logic              seq_d;
  logic              wrap_d;
  logic              err_evt;

  johnson_code_decode #(.N(N)) u_decode (
    .code  (code_q),
    .legal (legal),
    .index (idx)
  );

  // 2N need not be a power of two, so wrap the successor explicitly.
  assign succ    = (ref_q == LAST_IDX) ? '0 : ref_q + 1'b1;
  assign is_succ = (idx == succ);
  assign err_evt = valid_q & (~legal | seq_d);

  // NOTE: every variable gets its default before any branch so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    seq_d   = 1'b0;
    wrap_d  = 1'b0;
    if (valid_q) begin
      if (!legal) begin
        state_d = UNLOCKED;
      end else begin
        ref_d = idx;
        unique case (state_q)
          UNLOCKED: begin
            good_d  = '0;
            state_d = ACQUIRE;
          end
          ACQUIRE: begin
            if (is_succ) begin
              good_d = good_q + 1'b1;
              if (int'(good_q) + 1 >= LOCK_CNT) state_d = LOCKED;
            end else begin
              good_d = '0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              wrap_d = (ref_q == LAST_IDX);
            end else begin
              seq_d   = 1'b1;
              good_d  = '0;
              state_d = ACQUIRE;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge
  // values; reset is asynchronous assert, released synchronously upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q           <= '0;
      valid_q          <= 1'b0;
      state_q          <= UNLOCKED;
      ref_q            <= '0;
      good_q           <= '0;
      bus.index_out    <= '0;
      bus.index_valid  <= 1'b0;
      bus.illegal_code <= 1'b0;
      bus.seq_error    <= 1'b0;
      bus.wrap_pulse   <= 1'b0;
      bus.locked       <= 1'b0;
      bus.err_count    <= '0;
    end else begin
      code_q           <= bus.code_in;
      valid_q          <= bus.code_valid;
      state_q          <= state_d;
      ref_q            <= ref_d;
      good_q           <= good_d;
      bus.index_valid  <= valid_q & legal;
      bus.illegal_code <= valid_q & ~legal;
      bus.seq_error    <= seq_d;
      bus.wrap_pulse   <= wrap_d;
      bus.locked       <= (state_d == LOCKED);
      if (valid_q && legal) bus.index_out <= idx;
      if (err_evt && bus.err_count != '1) bus.err_count <= bus.err_count + 1'b1;
    end
  end

endmodule
